// File: rtl/tm1638_key_reader_if.sv
// rtl/tm1638_key_reader_if.sv - request/result and TM1638 serial bus signals of the key reader
interface tm1638_key_reader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  keys;
  logic [31:0] raw;
  logic        stb_n;
  logic        sclk;
  logic        dio_out;
  logic        dio_oe;
  logic        dio_in;

  // Requester and pin side: issues start, sees results, returns the DIO pin value.
  modport master (
    output start,
    output dio_in,
    input  busy,
    input  done,
    input  keys,
    input  raw,
    input  stb_n,
    input  sclk,
    input  dio_out,
    input  dio_oe
  );

  // The key reader itself.
  modport slave (
    input  start,
    input  dio_in,
    output busy,
    output done,
    output keys,
    output raw,
    output stb_n,
    output sclk,
    output dio_out,
    output dio_oe
  );
endinterface

// File: rtl/tm1638_key_reader.sv
// rtl/tm1638_key_reader.sv - TM1638 key-scan reader: sends 0x42, clocks in 4 scan bytes
module tm1638_key_reader #(
  parameter int unsigned CLK_DIV     = 50,
  parameter int unsigned WAIT_CYCLES = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  tm1638_key_reader_if.slave   bus
);

  // One counter serves both the sclk half-period and the turnaround wait.
  localparam int unsigned MAX_CNT   = (CLK_DIV > WAIT_CYCLES) ? CLK_DIV : WAIT_CYCLES;
  localparam int unsigned CW        = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [7:0]    READ_CMD  = 8'h42;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_WAIT, S_READ, S_HOLD, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          phase;     // 0 = sclk low half, 1 = sclk high half
  logic [4:0]    bit_cnt;
  logic [31:0]   shreg;
  logic [7:0]    keys_q;
  logic [31:0]   raw_q;
  logic [1:0]    dio_sync;

  logic half_end;
  logic wait_end;
  logic bit_last;

  logic stb_n_c, sclk_c, dio_out_c, dio_oe_c, busy_c, done_c;

  assign half_end = (cnt == HALF_LAST);
  assign wait_end = (cnt == WAIT_LAST);
  assign bit_last = (state == S_CMD) ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: each phase ends on its own counter terminal count.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (bus.start) next_state = S_SETUP;
      S_SETUP: if (half_end) next_state = S_CMD;
      S_CMD:   if (half_end && phase && bit_last) next_state = S_WAIT;
      S_WAIT:  if (wait_end) next_state = S_READ;
      S_READ:  if (half_end && phase && bit_last) next_state = S_HOLD;
      S_HOLD:  if (half_end) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore outputs: bus levels follow the state, half-phase and current command bit.
  always_comb begin
    stb_n_c   = 1'b1;
    sclk_c    = 1'b1;
    dio_out_c = 1'b1;
    dio_oe_c  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      S_SETUP: begin
        stb_n_c  = 1'b0;
        busy_c   = 1'b1;
        dio_oe_c = 1'b1;
      end
      S_CMD: begin
        stb_n_c   = 1'b0;
        busy_c    = 1'b1;
        dio_oe_c  = 1'b1;
        sclk_c    = phase;
        dio_out_c = READ_CMD[bit_cnt[2:0]];
      end
      S_WAIT, S_HOLD: begin
        stb_n_c = 1'b0;
        busy_c  = 1'b1;
      end
      S_READ: begin
        stb_n_c = 1'b0;
        busy_c  = 1'b1;
        sclk_c  = phase;
      end
      S_DONE:  done_c = 1'b1;
      default: ;
    endcase
  end

  // Two-flop synchroniser for the DIO pin; the line idles high.
  always_ff @(posedge clk) begin
    if (rst) dio_sync <= 2'b11;
    else     dio_sync <= {dio_sync[0], bus.dio_in};
  end

  // Counters and shift register; counters are cleared outside their states.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      phase   <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_SETUP, S_HOLD: cnt <= half_end ? '0 : cnt + 1'b1;
        S_WAIT:          cnt <= wait_end ? '0 : cnt + 1'b1;
        S_CMD, S_READ: begin
          if (half_end) begin
            cnt   <= '0;
            phase <= ~phase;
            if (phase) bit_cnt <= bit_last ? 5'd0 : bit_cnt + 5'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
          // Sample in the first high cycle so the synchroniser has caught up with the bit.
          if (state == S_READ && phase && cnt == '0)
            shreg <= {dio_sync[1], shreg[31:1]};
        end
        default: begin
          cnt     <= '0;
          phase   <= 1'b0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Results are published on entry to DONE so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      raw_q  <= '0;
    end else if (state == S_HOLD && next_state == S_DONE) begin
      raw_q  <= shreg;
      keys_q <= {shreg[28], shreg[20], shreg[12], shreg[4],
                 shreg[24], shreg[16], shreg[8],  shreg[0]};
    end
  end

  assign bus.stb_n   = stb_n_c;
  assign bus.sclk    = sclk_c;
  assign bus.dio_out = dio_out_c;
  assign bus.dio_oe  = dio_oe_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.keys    = keys_q;
  assign bus.raw     = raw_q;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb/tb_tm1638_key_reader.sv - self-checking bench for tm1638_key_reader with a TM1638 pin model
module tb_tm1638_key_reader;

  localparam int CD = 2;
  localparam int WC = 4;
  localparam int LAT = 1 + 82 * CD + WC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  tm1638_key_reader_if bus ();

  tm1638_key_reader #(.CLK_DIV(CD), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Chip model and bus monitor state.
  logic [31:0] scan_word = 32'h0;
  int          rises = 0;
  int          last_rises = 0;
  logic [7:0]  cmd_cap = 8'h0;
  logic [7:0]  last_cmd = 8'h0;
  int          done_count = 0;
  logic        prev_sclk = 1'b1;
  logic        prev_stb = 1'b1;
  logic        prev_rst = 1'b1;
  logic [7:0]  prev_keys = 8'h0;
  logic        keys_bad = 1'b0;
  logic        oe_bad = 1'b0;

  initial bus.dio_in = 1'b1;

  // TM1638 model: after the 8 command bits it drives scan bits LSB first on each sclk fall.
  always @(negedge clk) begin
    if (bus.stb_n || rst) begin
      if (!prev_stb && bus.stb_n) begin
        last_rises = rises;
        last_cmd   = cmd_cap;
      end
      rises      = 0;
      cmd_cap    = 8'h0;
      bus.dio_in = 1'b1;
    end else begin
      if (!prev_sclk && bus.sclk) begin
        if (rises < 8) cmd_cap[rises] = bus.dio_out;
        rises = rises + 1;
      end
      if (prev_sclk && !bus.sclk && rises >= 8 && rises < 40)
        bus.dio_in = scan_word[rises - 8];
      if (bus.dio_oe && rises >= 9) oe_bad = 1'b1;
    end
    if (bus.done) done_count = done_count + 1;
    if (bus.keys !== prev_keys && !bus.done && !rst && !prev_rst) keys_bad = 1'b1;
    prev_sclk = bus.sclk;
    prev_stb  = bus.stb_n;
    prev_rst  = rst;
    prev_keys = bus.keys;
  end

  function automatic logic [7:0] key_model(input logic [31:0] w);
    logic [7:0] k;
    for (int i = 0; i < 4; i++) begin
      k[i]     = w[8 * i];
      k[i + 4] = w[8 * i + 4];
    end
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_at(input int c, output int t0);
    wait_until(c);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_start(input int c);
    wait_until(c);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 400);
    check("done_seen", 32'(bus.done), 32'd1);
    dc = cyc;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int dc;
    int dcount;
    logic [31:0] w;

    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stb_n",   32'(bus.stb_n),   32'd1);
    check("rst_sclk",    32'(bus.sclk),    32'd1);
    check("rst_dio_oe",  32'(bus.dio_oe),  32'd0);
    check("rst_dio_out", 32'(bus.dio_out), 32'd1);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_done",    32'(bus.done),    32'd0);
    check("rst_keys",    32'(bus.keys),    32'd0);
    check("rst_raw",     bus.raw,          32'd0);
    rst = 1'b0;

    // Scan 1: fixed pattern from the LED&KEY example.
    scan_word = 32'h1100_1001;
    wait_until(10);
    check("s1_stb_before", 32'(bus.stb_n), 32'd1);
    start_at(10, t0);
    check("s1_stb_fall", 32'(bus.stb_n), 32'd0);
    check("s1_busy",     32'(bus.busy),  32'd1);
    wait_until(t0 + 3 + 16 * CD - 1);
    check("s1_oe_last_cmd", 32'(bus.dio_oe), 32'd1);
    @(negedge clk);
    check("s1_oe_wait",   32'(bus.dio_oe), 32'd0);
    check("s1_sclk_wait", 32'(bus.sclk),   32'd1);
    wait_done(dc);
    check("s1_done_cycle", 32'(dc), 32'(t0 + LAT));
    check("s1_done_at_179", 32'(dc), 32'd179);
    check("s1_busy_done", 32'(bus.busy), 32'd0);
    check("s1_raw",  bus.raw,        32'h1100_1001);
    check("s1_keys", 32'(bus.keys),  32'(key_model(32'h1100_1001)));
    check("s1_keys_a9", 32'(bus.keys), 32'h0000_00A9);
    @(negedge clk);
    check("s1_cmd_bits", 32'(last_cmd),  32'h42);
    check("s1_rises",    32'(last_rises), 32'd40);

    // Scan 2: all-zero keys, with stray starts while busy.
    scan_word = 32'h0;
    dcount = done_count;
    start_at(cyc + 5, t0);
    pulse_start(t0 + 20);
    wait_until(t0 + 100);
    check("s2_keys_hold", 32'(bus.keys), 32'h0000_00A9);
    pulse_start(t0 + 100);
    wait_done(dc);
    check("s2_done_cycle", 32'(dc), 32'(t0 + LAT));
    check("s2_raw",  bus.raw,       32'd0);
    check("s2_keys", 32'(bus.keys), 32'd0);
    wait_until(dc + 30);
    check("s2_idle_busy", 32'(bus.busy),  32'd0);
    check("s2_idle_stb",  32'(bus.stb_n), 32'd1);
    check("s2_one_done",  32'(done_count), 32'(dcount + 1));

    // Scan 3: reset in READ bit 12 aborts the transfer.
    scan_word = $urandom;
    start_at(cyc + 3, t0);
    wait_until(t0 + 88);
    check("ab_in_read", 32'(bus.stb_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("ab_stb_n", 32'(bus.stb_n), 32'd1);
    check("ab_sclk",  32'(bus.sclk),  32'd1);
    check("ab_busy",  32'(bus.busy),  32'd0);
    check("ab_keys",  32'(bus.keys),  32'd0);
    check("ab_raw",   bus.raw,        32'd0);
    rst = 1'b0;
    dcount = done_count;
    wait_until(cyc + 200);
    check("ab_no_done", 32'(done_count), 32'(dcount));

    // Random scans, each new start issued in the cycle after the previous done.
    start_at(cyc + 3, t0);
    for (int s = 0; s < 4; s++) begin
      w = scan_word;
      check("rs_stb_fall", 32'(bus.stb_n), 32'd0);
      wait_done(dc);
      check("rs_done_cycle", 32'(dc), 32'(t0 + LAT));
      check("rs_raw",  bus.raw,       w);
      check("rs_keys", 32'(bus.keys), 32'(key_model(w)));
      @(negedge clk);
      check("rs_cmd_bits", 32'(last_cmd),   32'h42);
      check("rs_rises",    32'(last_rises), 32'd40);
      if (s < 3) begin
        scan_word = $urandom;
        start_at(cyc, t0);
      end
    end

    check("keys_stable", 32'(keys_bad), 32'd0);
    check("oe_released", 32'(oe_bad),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
